div_clk_monitor: RTL

Receiving-end checker for divided clocks produced elsewhere in the design. It samples a slow clock or square wave asynchronously and synchronizes it into the clk_in domain. It measures high time and full period in clk_in cycles and flags deviations from expected values. It sits beside the clock dividers as an on-chip self-check and lab-debug observer.

---
 rtl/div_clk_monitor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// Receiving-end checker for a divided clock: synchronizes sig_in, measures high time and period
// in clk_in cycles, and flags out-of-tolerance results and missing edges. Define MEAS_COUNT_EN to add meas_count.
module div_clk_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EXP_HIGH    = 6,
   parameter int unsigned EXP_PERIOD  = 11,
   parameter int unsigned TOL         = 0,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   input  logic             clr,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             mismatch,
   output logic             timeout
`ifdef MEAS_COUNT_EN
   ,
   output logic [7:0]       meas_count
`endif
);

   localparam int unsigned      SYNC_W       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] EXP_HIGH_C   = CNT_W'(EXP_HIGH);
   localparam logic [CNT_W-1:0] EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] TOL_C        = CNT_W'(TOL);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [SYNC_W-1:0] sync_q, sync_d;
   logic              s_dly_q, s_dly_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  high_latch_q, high_latch_d;
   logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
   logic              meas_valid_q, meas_valid_d;
   logic              mismatch_q, mismatch_d;
   logic              timeout_q, timeout_d;

   logic              s;
   logic              rise;
   logic              fall;
   logic [CNT_W-1:0]  cnt_inc;
   logic              out_of_tol;

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Synchronizer chain plus one delay flop for edge detection
   always_comb begin
      sync_d  = {sync_q[SYNC_W-2:0], sig_in};
      s_dly_d = sync_q[SYNC_W-1];
   end

   assign s    = sync_q[SYNC_W-1];
   assign rise = s & ~s_dly_q;
   assign fall = ~s & s_dly_q;

   // Saturating increment; only reachable if TIMEOUT is misconfigured
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));

   // Evaluated on the values about to be reported at a rise in LOW
   assign out_of_tol = (abs_diff(high_latch_q, EXP_HIGH_C) > TOL_C) ||
                       (abs_diff(cnt_q, EXP_PERIOD_C) > TOL_C);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      high_latch_d = high_latch_q;
      high_cnt_d   = high_cnt_q;
      period_cnt_d = period_cnt_q;
      meas_valid_d = 1'b0;
      mismatch_d   = clr ? 1'b0 : mismatch_q;
      timeout_d    = clr ? 1'b0 : timeout_q;

      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               cnt_d = '0;
               if (rise) begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (fall) begin
                  high_latch_d = cnt_q;
                  cnt_d        = cnt_inc;
                  state_d      = ST_LOW;
               end else if (cnt_q >= TIMEOUT_C) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_ARM;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_LOW: begin
               if (rise) begin
                  period_cnt_d = cnt_q;
                  high_cnt_d   = high_latch_q;
                  meas_valid_d = 1'b1;
                  cnt_d        = CNT_W'(1);
                  state_d      = ST_HIGH;
                  if (out_of_tol) begin
                     mismatch_d = 1'b1;
                  end
               end else if (cnt_q >= TIMEOUT_C) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_ARM;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sync_q       <= '0;
         s_dly_q      <= 1'b0;
         cnt_q        <= '0;
         high_latch_q <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         meas_valid_q <= 1'b0;
         mismatch_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         s_dly_q      <= s_dly_d;
         cnt_q        <= cnt_d;
         high_latch_q <= high_latch_d;
         high_cnt_q   <= high_cnt_d;
         period_cnt_q <= period_cnt_d;
         meas_valid_q <= meas_valid_d;
         mismatch_q   <= mismatch_d;
         timeout_q    <= timeout_d;
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign meas_valid = meas_valid_q;
   assign mismatch   = mismatch_q;
   assign timeout    = timeout_q;

`ifdef MEAS_COUNT_EN
   logic [7:0] meas_count_q, meas_count_d;

   // Report counter; survives enable=0, clr takes priority over a same-cycle increment
   always_comb begin
      meas_count_d = meas_count_q;
      if (clr) begin
         meas_count_d = '0;
      end else if (meas_valid_d) begin
         meas_count_d = meas_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         meas_count_q <= '0;
      end else begin
         meas_count_q <= meas_count_d;
      end
   end

   assign meas_count = meas_count_q;
`endif

endmodule
